// File: rtl/wm8731_cfg_sequencer.sv
// WM8731 power-up sequencer: writes 11 codec registers as I2C packets and polls busy after each.
// 3 cycles per entry unstalled (done at start+33); m_waitrequest holds the request with address/data stable.
module wm8731_cfg_sequencer #(
  parameter logic [15:0] TIMEOUT = 16'd1000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [3:0]  index,
  output logic        m_read,
  output logic        m_write,
  output logic        m_chipselect,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  input  logic        m_waitrequest
);
  localparam logic [2:0] ADDR_I2C = 3'd0;
  localparam logic [7:0] CMD_BYTE = 8'h01;
  localparam int         BUSY_BIT = 31;
  localparam logic [3:0] LAST_IDX = 4'd10;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CHK, S_DONE, S_ERR} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_index;
  logic [15:0] r_poll_cnt;
  logic        r_busy_bit;
  logic        w_accept;
  logic [15:0] w_poll_inc;
  logic [23:0] w_packet;
  logic        w_unused_rd;

  assign w_accept    = start && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign w_poll_inc  = (r_poll_cnt == 16'hFFFF) ? r_poll_cnt : r_poll_cnt + 16'd1;
  assign w_unused_rd = &{1'b0, m_readdata[30:0]};
  assign index       = r_index;

  // Packet = {device addr 0x34, reg[6:0], data[8:0]}; R15 reset goes first, R9 activate last.
  always_comb begin
    case (r_index)
      4'd0:    w_packet = 24'h341E00;
      4'd1:    w_packet = 24'h340017;
      4'd2:    w_packet = 24'h340217;
      4'd3:    w_packet = 24'h340479;
      4'd4:    w_packet = 24'h340679;
      4'd5:    w_packet = 24'h340812;
      4'd6:    w_packet = 24'h340A00;
      4'd7:    w_packet = 24'h340C00;
      4'd8:    w_packet = 24'h340E02;
      4'd9:    w_packet = 24'h341000;
      4'd10:   w_packet = 24'h341201;
      default: w_packet = 24'h000000;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_accept) w_next = S_WR;
      S_WR:  if (!m_waitrequest) w_next = S_RD;
      S_RD:  if (!m_waitrequest) w_next = S_CHK;
      S_CHK: begin
        if (!r_busy_bit) begin
          w_next = (r_index == LAST_IDX) ? S_DONE : S_WR;
        end else begin
          w_next = (w_poll_inc >= TIMEOUT) ? S_ERR : S_RD;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy         = (r_state == S_WR) || (r_state == S_RD) || (r_state == S_CHK);
    done         = (r_state == S_DONE);
    error        = (r_state == S_ERR);
    m_write      = (r_state == S_WR);
    m_read       = (r_state == S_RD);
    m_chipselect = m_write || m_read;
    m_address    = m_chipselect ? ADDR_I2C : 3'd0;
    m_writedata  = m_write ? {CMD_BYTE, w_packet} : 32'd0;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_index    <= 4'd0;
      r_poll_cnt <= 16'd0;
      r_busy_bit <= 1'b0;
    end else if (w_accept) begin
      r_index    <= 4'd0;
      r_poll_cnt <= 16'd0;
      r_busy_bit <= 1'b0;
    end else if (r_state == S_RD && !m_waitrequest) begin
      r_busy_bit <= m_readdata[BUSY_BIT];
    end else if (r_state == S_CHK) begin
      if (!r_busy_bit) begin
        r_poll_cnt <= 16'd0;
        if (r_index != LAST_IDX) r_index <= r_index + 4'd1;
      end else begin
        r_poll_cnt <= w_poll_inc;
      end
    end
  end
endmodule

// File: tb/tb_wm8731_cfg_sequencer.sv
// Bench for wm8731_cfg_sequencer: randomized slave stalls and busy polls against a table/latency model.
module tb_wm8731_cfg_sequencer;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        start = 1'b0;
  logic        busy, done, error;
  logic [3:0]  index;
  logic        m_read, m_write, m_chipselect;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata = 32'd0;
  logic        m_waitrequest = 1'b0;

  wm8731_cfg_sequencer dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .index(index), .m_read(m_read), .m_write(m_write), .m_chipselect(m_chipselect),
    .m_address(m_address), .m_writedata(m_writedata), .m_readdata(m_readdata),
    .m_waitrequest(m_waitrequest)
  );

  initial forever #5 Clk = ~Clk;

  localparam logic [23:0] TBL [0:10] = '{24'h341E00, 24'h340017, 24'h340217, 24'h340479,
    24'h340679, 24'h340812, 24'h340A00, 24'h340C00, 24'h340E02, 24'h341000, 24'h341201};
  localparam int TMO = 1000;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int k = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Slave model state and transaction log
  int          wr_cnt, total_stall, req_total, rd_stall_max, stall_left;
  int          rd_per [11];
  int          hold_wr [11];
  int          stall_wr [11];
  int          busy_polls [11];
  logic [31:0] wq [$];
  bit          stuck, in_req, cap_wr;
  logic [2:0]  cap_addr;
  logic [31:0] cap_wd;

  task automatic slave_clear();
    wr_cnt = 0; total_stall = 0; req_total = 0; rd_stall_max = 0; stall_left = 0;
    stuck = 0; in_req = 0; wq.delete();
    for (int i = 0; i < 11; i++) begin
      rd_per[i] = 0; hold_wr[i] = 0; stall_wr[i] = 0; busy_polls[i] = 0;
    end
  endtask

  task automatic slave_proc();
    int  cur;
    bit  bv;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        m_waitrequest = 0; in_req = 0; stall_left = 0;
        continue;
      end
      checks++;
      if ((m_read && m_write) || (m_chipselect !== (m_read | m_write))) begin
        errors++;
        $display("FAIL bus_ctrl: rd=%b wr=%b cs=%b, need rd&wr=0 and cs=rd|wr", m_read, m_write, m_chipselect);
      end
      cur = wr_cnt - 1;
      bv = stuck;
      if (cur >= 0 && cur < 11) begin
        if (rd_per[cur] < busy_polls[cur]) bv = 1;
      end
      if (m_read || m_write) begin
        if (!in_req) begin
          in_req = 1; req_total++;
          cap_addr = m_address; cap_wd = m_writedata; cap_wr = m_write;
          if (m_write) stall_left = (wr_cnt < 11) ? stall_wr[wr_cnt] : 0;
          else stall_left = int'($urandom_range(rd_stall_max, 0));
          total_stall += stall_left;
          checks++;
          if (m_address !== 3'd0) begin
            errors++; $display("FAIL bus_addr: got %0d need 0", m_address);
          end
        end else begin
          checks++;
          if (m_write !== cap_wr || m_address !== cap_addr || (cap_wr && m_writedata !== cap_wd)) begin
            errors++;
            $display("FAIL req_stable: wr=%b addr=%0d wd=%h, held wr=%b addr=%0d wd=%h",
                     m_write, m_address, m_writedata, cap_wr, cap_addr, cap_wd);
          end
        end
        if (m_write && wr_cnt < 11) hold_wr[wr_cnt]++;
        if (stall_left > 0) begin
          m_waitrequest = 1; stall_left--;
          m_readdata = {~bv, 31'($urandom())};
        end else begin
          m_waitrequest = 0;
          m_readdata = {bv, 31'($urandom())};
          if (m_write) begin
            wq.push_back(m_writedata); wr_cnt++;
          end else if (cur >= 0 && cur < 11) begin
            rd_per[cur]++;
          end
          in_req = 0;
        end
      end else begin
        if (in_req) begin
          checks++; errors++;
          $display("FAIL req_dropped: request withdrawn before acceptance");
        end
        in_req = 0; m_waitrequest = 0; m_readdata = 32'd0;
      end
    end
  endtask

  task automatic pulse_start();
    @(negedge Clk); start = 1;
    @(negedge Clk); start = 0;
    k = cyc;
  endtask

  task automatic wait_end(input int budget, input bit poke, output int lat);
    lat = -1;
    for (int n = 0; n < budget; n++) begin
      if (done || error) begin
        lat = cyc - k;
        break;
      end
      @(negedge Clk);
      start = poke && ($urandom_range(5, 0) == 0);
    end
    start = 0;
  endtask

  task automatic test_reset();
    Rst_n = 0; slave_clear();
    repeat (3) @(negedge Clk);
    checks++;
    if ({busy, done, error, index, m_read, m_write, m_chipselect, m_address, m_writedata} !== 45'd0) begin
      errors++; $display("FAIL reset_outputs: busy=%b done=%b err=%b idx=%0d rd=%b wr=%b wd=%h, need all 0",
                         busy, done, error, index, m_read, m_write, m_writedata);
    end
    Rst_n = 1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({busy, done, error, index, m_read, m_write, m_chipselect} !== 10'd0) begin
      errors++; $display("FAIL idle_outputs: busy=%b done=%b err=%b idx=%0d rd=%b wr=%b, need all 0",
                         busy, done, error, index, m_read, m_write);
    end
  endtask

  task automatic test_basic();
    int lat;
    slave_clear();
    pulse_start();
    checks++;
    if (m_write !== 1'b1 || busy !== 1'b1 || m_writedata !== 32'h01341E00) begin
      errors++; $display("FAIL basic_first_edge: wr=%b busy=%b wd=%h, need 1 1 01341e00", m_write, busy, m_writedata);
    end
    wait_end(300, 0, lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL basic_latency: got %0d need 33", lat); end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0 || index !== 4'd10) begin
      errors++; $display("FAIL basic_final: done=%b busy=%b err=%b idx=%0d, need 1 0 0 10", done, busy, error, index);
    end
    checks++;
    if (wq.size() !== 11) begin errors++; $display("FAIL basic_wr_count: got %0d need 11", wq.size()); end
    for (int i = 0; i < 11 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {8'h01, TBL[i]}) begin
        errors++; $display("FAIL basic_wr_data[%0d]: got %h need %h", i, wq[i], {8'h01, TBL[i]});
      end
    end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (rd_per[i] !== 1) begin errors++; $display("FAIL basic_reads[%0d]: got %0d need 1", i, rd_per[i]); end
    end
    repeat (5) @(negedge Clk);
    checks++;
    if (req_total !== 22 || done !== 1'b1) begin
      errors++; $display("FAIL basic_quiet: reqs=%0d done=%b, need 22 1", req_total, done);
    end
  endtask

  task automatic test_wr_stall();
    int lat;
    slave_clear();
    stall_wr[0] = 3;
    pulse_start();
    wait_end(300, 0, lat);
    checks++;
    if (lat !== 36) begin errors++; $display("FAIL wr_stall_latency: got %0d need 36", lat); end
    checks++;
    if (hold_wr[0] !== 4) begin errors++; $display("FAIL wr_stall_hold: got %0d cycles need 4", hold_wr[0]); end
    checks++;
    if (wq.size() !== 11) begin errors++; $display("FAIL wr_stall_count: got %0d need 11", wq.size()); end
    for (int i = 0; i < 11 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {8'h01, TBL[i]}) begin
        errors++; $display("FAIL wr_stall_data[%0d]: got %h need %h", i, wq[i], {8'h01, TBL[i]});
      end
    end
  endtask

  task automatic test_busy_poll();
    int lat;
    slave_clear();
    busy_polls[4] = 5;
    pulse_start();
    wait_end(300, 0, lat);
    checks++;
    if (lat !== 43) begin errors++; $display("FAIL poll_latency: got %0d need 43", lat); end
    for (int i = 0; i < 11; i++) begin
      checks++;
      if (rd_per[i] !== ((i == 4) ? 6 : 1)) begin
        errors++; $display("FAIL poll_reads[%0d]: got %0d need %0d", i, rd_per[i], (i == 4) ? 6 : 1);
      end
    end
    checks++;
    if (wq.size() !== 11 || done !== 1'b1) begin
      errors++; $display("FAIL poll_final: writes=%0d done=%b, need 11 1", wq.size(), done);
    end
  endtask

  task automatic test_back_to_back();
    int lat, exp, polls;
    for (int it = 0; it < 3; it++) begin
      slave_clear();
      rd_stall_max = 2;
      polls = 0;
      for (int i = 0; i < 11; i++) begin
        stall_wr[i] = int'($urandom_range(3, 0));
        busy_polls[i] = int'($urandom_range(3, 0));
        polls += busy_polls[i];
      end
      pulse_start();
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || index !== 4'd0) begin
        errors++; $display("FAIL b2b_restart[%0d]: done=%b busy=%b idx=%0d, need 0 1 0", it, done, busy, index);
      end
      wait_end(1000, 0, lat);
      exp = 33 + total_stall + 2 * polls;
      checks++;
      if (lat !== exp) begin errors++; $display("FAIL b2b_latency[%0d]: got %0d need %0d", it, lat, exp); end
      checks++;
      if (wq.size() !== 11) begin errors++; $display("FAIL b2b_count[%0d]: got %0d need 11", it, wq.size()); end
      for (int i = 0; i < 11 && i < wq.size(); i++) begin
        checks++;
        if (wq[i] !== {8'h01, TBL[i]} || rd_per[i] !== busy_polls[i] + 1) begin
          errors++; $display("FAIL b2b_entry[%0d.%0d]: wd=%h reads=%0d need %h %0d",
                             it, i, wq[i], rd_per[i], {8'h01, TBL[i]}, busy_polls[i] + 1);
        end
      end
    end
  endtask

  task automatic test_start_ignored();
    int lat;
    slave_clear();
    pulse_start();
    wait_end(300, 1, lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL ignore_latency: got %0d need 33", lat); end
    checks++;
    if (wq.size() !== 11) begin errors++; $display("FAIL ignore_count: got %0d need 11", wq.size()); end
    for (int i = 0; i < 11 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {8'h01, TBL[i]}) begin
        errors++; $display("FAIL ignore_data[%0d]: got %h need %h", i, wq[i], {8'h01, TBL[i]});
      end
    end
  endtask

  task automatic test_timeout();
    int lat;
    slave_clear();
    stuck = 1;
    pulse_start();
    wait_end(5000, 0, lat);
    checks++;
    if (lat !== 1 + 2 * TMO) begin errors++; $display("FAIL tmo_latency: got %0d need %0d", lat, 1 + 2 * TMO); end
    checks++;
    if (error !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || index !== 4'd0) begin
      errors++; $display("FAIL tmo_final: err=%b done=%b busy=%b idx=%0d, need 1 0 0 0", error, done, busy, index);
    end
    checks++;
    if (wq.size() !== 1 || rd_per[0] !== TMO) begin
      errors++; $display("FAIL tmo_traffic: writes=%0d reads=%0d, need 1 %0d", wq.size(), rd_per[0], TMO);
    end
    repeat (20) @(negedge Clk);
    checks++;
    if (req_total !== 1 + TMO || error !== 1'b1) begin
      errors++; $display("FAIL tmo_quiet: reqs=%0d err=%b, need %0d 1", req_total, error, 1 + TMO);
    end
  endtask

  task automatic test_recover();
    int lat;
    slave_clear();
    pulse_start();
    checks++;
    if (error !== 1'b0 || busy !== 1'b1 || m_writedata !== 32'h01341E00) begin
      errors++; $display("FAIL recover_start: err=%b busy=%b wd=%h, need 0 1 01341e00", error, busy, m_writedata);
    end
    wait_end(300, 0, lat);
    checks++;
    if (lat !== 33 || done !== 1'b1 || error !== 1'b0 || wq.size() !== 11) begin
      errors++; $display("FAIL recover_run: lat=%0d done=%b err=%b writes=%0d, need 33 1 0 11",
                         lat, done, error, wq.size());
    end
  endtask

  task automatic test_async_reset();
    int  lat;
    bit  found;
    slave_clear();
    stall_wr[6] = 3;
    pulse_start();
    found = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge Clk); #1;
      if (m_write && wr_cnt == 6) begin found = 1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL arst_reach: entry 6 write not seen, wr_cnt=%0d need 6", wr_cnt); end
    #1 Rst_n = 0;
    #1;
    checks++;
    if ({busy, done, error, index, m_read, m_write, m_chipselect, m_address, m_writedata} !== 45'd0) begin
      errors++; $display("FAIL arst_outputs: busy=%b idx=%0d rd=%b wr=%b cs=%b wd=%h, need all 0",
                         busy, index, m_read, m_write, m_chipselect, m_writedata);
    end
    repeat (2) @(negedge Clk);
    Rst_n = 1;
    slave_clear();
    pulse_start();
    wait_end(300, 0, lat);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL arst_rerun_latency: got %0d need 33", lat); end
    checks++;
    if (wq.size() !== 11) begin errors++; $display("FAIL arst_rerun_count: got %0d need 11", wq.size()); end
    for (int i = 0; i < 11 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== {8'h01, TBL[i]}) begin
        errors++; $display("FAIL arst_rerun_data[%0d]: got %h need %h", i, wq[i], {8'h01, TBL[i]});
      end
    end
  endtask

  initial begin
    slave_clear();
    fork
      slave_proc();
    join_none
    test_reset();
    test_basic();
    test_wr_stall();
    test_busy_poll();
    test_back_to_back();
    test_start_ignored();
    test_timeout();
    test_recover();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
